// File: rtl/fetch_seq.sv
// fetch_seq -- instruction-fetch sequencer for the 16-bit core.
// It owns the fetch PC and walks it through FETCH/ISSUE. In FETCH it asks
// instruction memory for a word (req/ack). In ISSUE it hands that word to
// decode (valid/ready). Branch redirects from execute can arrive in any
// state except BOOT.
//
// Ports:
//   clock           system clock, rising edge
//   n_rst           asynchronous active-low reset
//   o_imem_req      fetch request to instruction memory
//   o_imem_addr     fetch address (the fetch PC)
//   i_imem_ack      memory response; i_imem_rdata is valid in the same cycle
//   i_imem_rdata    fetched instruction word
//   o_inst_valid    instruction available to decode
//   o_inst          latched instruction word
//   o_inst_pc       address the presented instruction was fetched from
//   i_inst_ready    decode accepts o_inst this cycle
//   i_halt          qualifies an accept: the accepted instruction is HALT
//   i_br_valid      branch redirect pulse from execute
//   i_br_target     redirect target PC
//   o_halted        sequencer is in HALT
//
// state | meaning
// BOOT  | first cycle after reset release, outputs idle
// FETCH | request outstanding at fetch PC, waiting for ack
// ISSUE | word presented to decode, waiting for accept
// HALT  | stopped after an accepted HALT, waiting for a redirect
module fetch_seq #(
  parameter int                 DATA_W    = 16,
  parameter logic [DATA_W-1:0]  RESET_VEC = '0
) (
  input  logic              clock,
  input  logic              n_rst,
  output logic              o_imem_req,
  output logic [DATA_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic              o_inst_valid,
  output logic [DATA_W-1:0] o_inst,
  output logic [DATA_W-1:0] o_inst_pc,
  input  logic              i_inst_ready,
  input  logic              i_halt,
  input  logic              i_br_valid,
  input  logic [DATA_W-1:0] i_br_target,
  output logic              o_halted
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_inst;
  logic [DATA_W-1:0] r_inst_pc;

  logic w_redirect;
  logic w_ack;
  logic w_accept;

  // A redirect overrides everything else in the same cycle: a concurrent ack
  // is thrown away, and a concurrent accept (and its halt flag) is void.
  assign w_redirect = i_br_valid && (r_state != BOOT);
  assign w_ack      = (r_state == FETCH) && i_imem_ack && !w_redirect;
  assign w_accept   = (r_state == ISSUE) && i_inst_ready && !w_redirect;

  // State register
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (w_redirect) begin
      w_next = FETCH;
    end else begin
      case (r_state)
        BOOT:  w_next = FETCH;
        FETCH: if (w_ack) w_next = ISSUE;
        ISSUE: if (w_accept) w_next = i_halt ? HALT : FETCH;
        HALT:  w_next = HALT;
        default: w_next = BOOT;
      endcase
    end
  end

  // Outputs decode from state and registers only, so no input reaches an
  // output within the same cycle.
  always_comb begin
    o_imem_req   = 1'b0;
    o_inst_valid = 1'b0;
    o_halted     = 1'b0;
    case (r_state)
      FETCH:   o_imem_req   = 1'b1;
      ISSUE:   o_inst_valid = 1'b1;
      HALT:    o_halted     = 1'b1;
      default: ;
    endcase
  end

  assign o_imem_addr = r_pc;
  assign o_inst      = r_inst;
  assign o_inst_pc   = r_inst_pc;

  // Fetch PC and the latched instruction. The PC wraps naturally at 2^DATA_W.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      r_pc      <= RESET_VEC;
      r_inst    <= '0;
      r_inst_pc <= '0;
    end else begin
      if (w_redirect) begin
        r_pc <= i_br_target;
      end else if (w_accept) begin
        r_pc <= r_pc + DATA_W'(1);
      end
      if (w_ack) begin
        r_inst    <= i_imem_rdata;
        r_inst_pc <= r_pc;
      end
    end
  end

endmodule
